sram_like_bridge: RTL and testbench

SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

---
 rtl/sram_like_bridge.sv | 124 ++++++++++++
 tb/tb_sram_like_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_bridge.sv
// Bridges a stalling in-order core port onto an sram-like bus (addr_ok/data_ok split handshake).
// Latency: min 3 cycles core_en->stall low; backpressure: core_stall holds the core until data_ok retires.
module sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              core_en,
    input  logic [3:0]        core_wen,
    input  logic [1:0]        core_size,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              state_q;
    logic                bus_req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          wen_q;
    logic [31:0]         wdata_q;
    logic [1:0]          size_q;
    logic [31:0]         rdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                is_read;

    // Bus size is resolved once at latch time: writes derive it from the byte lanes.
    function automatic logic [1:0] req_size(input logic [3:0] wen, input logic [1:0] sz);
        case (wen)
            4'b0000:          req_size = sz;
            4'b1111:          req_size = 2'd2;
            4'b0011, 4'b1100: req_size = 2'd1;
            default:          req_size = 2'd0;
        endcase
    endfunction

    assign is_read = (wen_q == 4'b0000);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            bus_req_q <= 1'b0;
            addr_q    <= '0;
            wen_q     <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (core_en) begin
                        addr_q    <= core_addr;
                        wen_q     <= core_wen;
                        wdata_q   <= core_wdata;
                        size_q    <= req_size(core_wen, core_size);
                        bus_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // data_ok before addr_ok belongs to no request of ours and is dropped.
                    if (bus_addr_ok) begin
                        bus_req_q <= 1'b0;
                        if (bus_data_ok) begin
                            state_q <= S_DONE;
                            if (is_read) rdata_q <= bus_rdata;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus_data_ok) begin
                        state_q <= S_DONE;
                        if (is_read) rdata_q <= bus_rdata;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall must rise in the accepting IDLE cycle itself, so it is decoded rather than registered.
    assign core_stall = resetn && ((state_q == S_REQ) || (state_q == S_WAIT) ||
                                   ((state_q == S_IDLE) && core_en));

    assign cnt_d = (core_stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wr     = |wen_q;
    assign bus_size   = size_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign core_rdata = rdata_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed and randomized accesses against a transaction-level model of the bridge.
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        core_en;
    logic [3:0]  core_wen;
    logic [1:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    logic [31:0] core_rdata, bus_addr, bus_wdata, stall_cnt;
    logic        core_stall, bus_req, bus_wr;
    logic [1:0]  bus_size;

    logic [31:0] core_rdata_s, bus_addr_s, bus_wdata_s;
    logic        core_stall_s, bus_req_s, bus_wr_s;
    logic [1:0]  bus_size_s;
    logic [3:0]  stall_cnt_s;

    int          checks = 0;
    int          errors = 0;
    longint      exp_cnt = 0;
    logic [31:0] exp_rdata = '0;
    int          hs_cnt = 0;
    int          exp_hs = 0;

    always #5 clk = ~clk;

    sram_like_bridge dut (
        .clk(clk), .resetn(resetn), .core_en(core_en), .core_wen(core_wen),
        .core_size(core_size), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall), .bus_req(bus_req),
        .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stall_cnt(stall_cnt)
    );

    sram_like_bridge #(.ADDR_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .core_en(core_en), .core_wen(core_wen),
        .core_size(core_size), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata_s), .core_stall(core_stall_s), .bus_req(bus_req_s),
        .bus_wr(bus_wr_s), .bus_size(bus_size_s), .bus_addr(bus_addr_s), .bus_wdata(bus_wdata_s),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stall_cnt(stall_cnt_s)
    );

    always @(posedge clk) begin
        if (resetn && bus_req && bus_addr_ok) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_size(input logic [3:0] wen, input logic [1:0] sz);
        if (wen == 4'b0000) return sz;
        if (wen == 4'b1111) return 2'd2;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        return 2'd0;
    endfunction

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    // One complete core access, acting as bus slave; starts and ends aligned to a negedge.
    task automatic access(input logic [3:0] wen, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int adly, input int ddly, input bit early, input bit hold);
        logic [1:0] esz;
        esz = exp_size(wen, size);
        @(negedge clk);
        core_en = 1'b1; core_wen = wen; core_size = size; core_addr = addr; core_wdata = wdata;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        chk("idle_stall", core_stall, 1);
        chk("idle_req", bus_req, 0);
        exp_cnt++;
        for (int k = 0; k <= adly; k++) begin
            @(negedge clk);
            core_addr = $urandom; core_wdata = $urandom; core_wen = 4'($urandom);
            bus_addr_ok = (k == adly);
            bus_data_ok = (k == adly) ? (ddly == 0) : (early && k == 0);
            bus_rdata   = (k == adly && ddly == 0) ? rdata : $urandom;
            #1;
            chk("req_vld", bus_req, 1);
            chk("req_addr", bus_addr, addr);
            chk("req_wdata", bus_wdata, wdata);
            chk("req_wr", bus_wr, (wen != 0));
            chk("req_size", bus_size, esz);
            chk("req_stall", core_stall, 1);
            exp_cnt++;
        end
        for (int j = 1; j <= ddly; j++) begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = (j == ddly);
            bus_rdata   = (j == ddly) ? rdata : $urandom;
            #1;
            chk("wait_req", bus_req, 0);
            chk("wait_stall", core_stall, 1);
            exp_cnt++;
        end
        if (wen == 4'b0000) exp_rdata = rdata;
        exp_hs++;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
        core_en = hold; core_wen = 4'($urandom); core_addr = $urandom;
        #1;
        chk("done_stall", core_stall, 0);
        chk("done_req", bus_req, 0);
        chk("done_rdata", core_rdata, exp_rdata);
        chk("done_cnt", 64'(stall_cnt), exp_cnt);
        chk("done_cnt4", 64'(stall_cnt_s), sat4(exp_cnt));
    endtask

    initial begin
        logic [3:0] wtab [9];
        wtab = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        resetn = 1'b0; core_en = 1'b1; core_wen = 4'hF; core_size = 2'd2;
        core_addr = 32'h1234_5678; core_wdata = 32'hA5A5_A5A5;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", bus_req, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_cnt", 64'(stall_cnt), 0);
        chk("rst_wr", bus_wr, 0);
        chk("rst_size", bus_size, 0);
        @(negedge clk);
        core_en = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; resetn = 1'b1;

        // Single-cycle read handshake.
        access(4'h0, 2'd2, 32'h1FC0_0000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        chk("fast_read_cnt", 64'(stall_cnt), 2);
        // Half-word write with addr_ok held off three cycles.
        access(4'h3, 2'd0, 32'h8000_0004, 32'h0BAD_F00D, 32'h1111_1111, 3, 1, 1'b0, 1'b0);
        // Early data_ok in REQ must be ignored.
        access(4'h0, 2'd1, 32'h0000_1000, 32'h0, 32'hCAFE_0001, 2, 2, 1'b1, 1'b0);
        // Back-to-back with core_en held through DONE.
        access(4'h0, 2'd0, 32'h0000_2000, 32'h0, 32'h0000_00AB, 0, 1, 1'b0, 1'b1);
        access(4'hF, 2'd2, 32'h0000_2004, 32'h7777_8888, 32'h0, 1, 0, 1'b0, 1'b1);
        access(4'h0, 2'd2, 32'h0000_2008, 32'h0, 32'h5555_AAAA, 0, 0, 1'b0, 1'b0);

        // Reset while waiting for data.
        @(negedge clk);
        core_en = 1'b1; core_wen = 4'hF; core_size = 2'd0; core_addr = 32'h4000_0000; core_wdata = $urandom;
        @(negedge clk);
        bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
        exp_hs++;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        #1;
        chk("mid_wait_req", bus_req, 0);
        chk("mid_wait_stall", core_stall, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("arst_req", bus_req, 0);
        chk("arst_stall", core_stall, 0);
        chk("arst_cnt", 64'(stall_cnt), 0);
        chk("arst_cnt4", 64'(stall_cnt_s), 0);
        chk("arst_rdata", core_rdata, 0);
        chk("arst_wr", bus_wr, 0);
        chk("arst_size", bus_size, 0);
        exp_cnt = 0; exp_rdata = '0;
        @(negedge clk);
        resetn = 1'b1; core_en = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_req", bus_req, 0);
            chk("post_rst_stall", core_stall, 0);
            chk("post_rst_rdata", core_rdata, 0);
            chk("post_rst_cnt", 64'(stall_cnt), 0);
        end
        bus_data_ok = 1'b0;

        // Long addr_ok stall saturates the narrow counter.
        access(4'h0, 2'd2, 32'h0000_3000, 32'h0, 32'h0123_4567, 20, 0, 1'b0, 1'b0);
        chk("sat_cnt4", 64'(stall_cnt_s), 15);

        for (int n = 0; n < 40; n++) begin
            int         idx;
            logic [3:0] w;
            idx = $urandom_range(0, 9);
            if (idx == 9) w = 4'($urandom);
            else          w = wtab[idx];
            access(w, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        core_en = 1'b0;
        #1;
        chk("final_idle_req", bus_req, 0);
        chk("final_idle_stall", core_stall, 0);
        @(negedge clk);
        chk("handshakes", 64'(hs_cnt), 64'(exp_hs));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
